// File: rtl/pong_pkg.sv
// Shared Pong definitions: screen/object geometry, colours, sequencer states and draw-op encoding.
// Also reused by the game controller so both blocks agree on object sizes.
package pong_pkg;

  localparam int PONG_BALL_SIZE      = 4;
  localparam int PONG_PADDLE_HEIGHT  = 32;
  localparam int PONG_PADDLE_DEPTH   = 8;
  localparam int PONG_LEFT_PADDLE_X  = 16;
  localparam int PONG_RIGHT_PADDLE_X = 776;
  localparam int PONG_X_SCREEN       = 800;
  localparam int PONG_Y_SCREEN       = 600;

  localparam logic [2:0] PONG_BG_COLOR = 3'b000;
  localparam logic [2:0] PONG_FG_COLOR = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    DRAW  = 2'd2,
    TICK  = 2'd3
  } seq_state_e;

  typedef enum logic [1:0] {
    OP_BALL  = 2'd0,
    OP_LEFT  = 2'd1,
    OP_RIGHT = 2'd2
  } op_e;

  typedef struct packed {
    logic valid;
    op_e  op;
  } next_op_t;

  // Next op in the same phase after cur; valid=0 when the phase is exhausted.
  function automatic next_op_t next_op(input op_e cur, input logic skip_left, input logic skip_right);
    next_op_t r;
    r.valid = 1'b0;
    r.op    = OP_BALL;
    case (cur)
      OP_BALL: begin
        if (!skip_left) begin
          r.valid = 1'b1;
          r.op    = OP_LEFT;
        end else if (!skip_right) begin
          r.valid = 1'b1;
          r.op    = OP_RIGHT;
        end else begin
          r.valid = 1'b0;
        end
      end
      OP_LEFT: begin
        if (!skip_right) begin
          r.valid = 1'b1;
          r.op    = OP_RIGHT;
        end else begin
          r.valid = 1'b0;
        end
      end
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pong_rect_mux.sv
// Combinational selection of the fill rectangle for one draw op: which object, erase or draw,
// and old or new position. ERASE on the first frame selects a full-screen clear instead.
module pong_rect_mux
  import pong_pkg::*;
#(
  parameter int         BALL_SIZE       = PONG_BALL_SIZE,
  parameter int         PADDLE_HEIGHT   = PONG_PADDLE_HEIGHT,
  parameter int         PADDLE_DEPTH    = PONG_PADDLE_DEPTH,
  parameter int         LEFT_PADDLE_X   = PONG_LEFT_PADDLE_X,
  parameter int         RIGHT_PADDLE_X  = PONG_RIGHT_PADDLE_X,
  parameter int         X_SCREEN_PIXELS = PONG_X_SCREEN,
  parameter int         Y_SCREEN_PIXELS = PONG_Y_SCREEN,
  parameter logic [2:0] BG_COLOR        = PONG_BG_COLOR,
  parameter logic [2:0] FG_COLOR        = PONG_FG_COLOR
) (
  input  op_e        op_i,
  input  seq_state_e phase_i,
  input  logic       first_frame_i,
  input  logic [9:0] old_ball_x_i,
  input  logic [9:0] old_ball_y_i,
  input  logic [9:0] old_left_y_i,
  input  logic [9:0] old_right_y_i,
  input  logic [9:0] new_ball_x_i,
  input  logic [9:0] new_ball_y_i,
  input  logic [9:0] new_left_y_i,
  input  logic [9:0] new_right_y_i,
  output logic [9:0] rect_x_o,
  output logic [9:0] rect_y_o,
  output logic [9:0] rect_w_o,
  output logic [9:0] rect_h_o,
  output logic [2:0] rect_color_o
);

  localparam logic [9:0] BALL_W  = 10'(BALL_SIZE);
  localparam logic [9:0] PAD_H   = 10'(PADDLE_HEIGHT);
  localparam logic [9:0] PAD_W   = 10'(PADDLE_DEPTH);
  localparam logic [9:0] LEFT_X  = 10'(LEFT_PADDLE_X);
  localparam logic [9:0] RIGHT_X = 10'(RIGHT_PADDLE_X);
  localparam logic [9:0] SCR_W   = 10'(X_SCREEN_PIXELS);
  localparam logic [9:0] SCR_H   = 10'(Y_SCREEN_PIXELS);

  logic       draw_s;
  logic [9:0] ball_x_s;
  logic [9:0] ball_y_s;
  logic [9:0] left_y_s;
  logic [9:0] right_y_s;

  // Rectangle payload for the selected op and phase.
  always_comb begin
    draw_s       = (phase_i == DRAW);
    ball_x_s     = draw_s ? new_ball_x_i  : old_ball_x_i;
    ball_y_s     = draw_s ? new_ball_y_i  : old_ball_y_i;
    left_y_s     = draw_s ? new_left_y_i  : old_left_y_i;
    right_y_s    = draw_s ? new_right_y_i : old_right_y_i;
    rect_x_o     = 10'd0;
    rect_y_o     = 10'd0;
    rect_w_o     = 10'd0;
    rect_h_o     = 10'd0;
    rect_color_o = BG_COLOR;
    if ((phase_i == ERASE) && first_frame_i) begin
      rect_w_o = SCR_W;
      rect_h_o = SCR_H;
    end else if ((phase_i == ERASE) || (phase_i == DRAW)) begin
      rect_color_o = draw_s ? FG_COLOR : BG_COLOR;
      case (op_i)
        OP_BALL: begin
          rect_x_o = ball_x_s;
          rect_y_o = ball_y_s;
          rect_w_o = BALL_W;
          rect_h_o = BALL_W;
        end
        OP_LEFT: begin
          rect_x_o = LEFT_X;
          rect_y_o = left_y_s;
          rect_w_o = PAD_W;
          rect_h_o = PAD_H;
        end
        OP_RIGHT: begin
          rect_x_o = RIGHT_X;
          rect_y_o = right_y_s;
          rect_w_o = PAD_W;
          rect_h_o = PAD_H;
        end
        default: begin
          rect_x_o = 10'd0;
          rect_y_o = 10'd0;
          rect_w_o = 10'd0;
          rect_h_o = 10'd0;
        end
      endcase
    end else begin
      rect_color_o = BG_COLOR;
    end
  end

endmodule

// File: rtl/pong_draw_sequencer.sv
// Per-frame erase/draw sequencer sharing one rect-fill engine among ball and paddles, then ticking the game.
// Optional PONG_SKIP_STATIC_EN: skip paddle erase/draw when the paddle did not move.
module pong_draw_sequencer
  import pong_pkg::*;
#(
  parameter int         BALL_SIZE       = PONG_BALL_SIZE,
  parameter int         PADDLE_HEIGHT   = PONG_PADDLE_HEIGHT,
  parameter int         PADDLE_DEPTH    = PONG_PADDLE_DEPTH,
  parameter int         LEFT_PADDLE_X   = PONG_LEFT_PADDLE_X,
  parameter int         RIGHT_PADDLE_X  = PONG_RIGHT_PADDLE_X,
  parameter int         X_SCREEN_PIXELS = PONG_X_SCREEN,
  parameter int         Y_SCREEN_PIXELS = PONG_Y_SCREEN,
  parameter logic [2:0] BG_COLOR        = PONG_BG_COLOR,
  parameter logic [2:0] FG_COLOR        = PONG_FG_COLOR,
  parameter int         TICK_DIV        = 1
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       frame_start,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic [9:0] left_y,
  input  logic [9:0] right_y,
  output logic       rect_valid,
  input  logic       rect_ready,
  output logic [9:0] rect_x,
  output logic [9:0] rect_y,
  output logic [9:0] rect_w,
  output logic [9:0] rect_h,
  output logic [2:0] rect_color,
  output logic       game_enable,
  output logic       busy,
  output logic       overrun
);

  localparam logic [3:0] TICK_DIV_C = 4'(TICK_DIV);

  seq_state_e state_q;
  op_e        op_q;
  logic       first_frame_q;
  logic       valid_q;
  logic       busy_q;
  logic       overrun_q;
  logic       game_enable_q;
  logic [3:0] tick_cnt_q;
  logic [9:0] old_ball_x_q, old_ball_y_q, old_left_y_q, old_right_y_q;
  logic [9:0] new_ball_x_q, new_ball_y_q, new_left_y_q, new_right_y_q;
  logic [9:0] rect_x_q, rect_y_q, rect_w_q, rect_h_q;
  logic [2:0] rect_color_q;

  logic       skip_left_s;
  logic       skip_right_s;
  op_e        sel_op_s;
  seq_state_e sel_phase_s;
  next_op_t   nxt_op_s;
  logic [9:0] rect_x_d, rect_y_d, rect_w_d, rect_h_d;
  logic [2:0] rect_color_d;

  // Op selection for the payload mux and the successor op within the current phase.
  always_comb begin
`ifdef PONG_SKIP_STATIC_EN
    skip_left_s  = !first_frame_q && (new_left_y_q == old_left_y_q);
    skip_right_s = !first_frame_q && (new_right_y_q == old_right_y_q);
`else
    skip_left_s  = 1'b0;
    skip_right_s = 1'b0;
`endif
    if (state_q == IDLE) begin
      // The first op of a frame is loaded straight out of IDLE; it never depends on new positions.
      sel_op_s    = OP_BALL;
      sel_phase_s = ERASE;
    end else begin
      sel_op_s    = op_q;
      sel_phase_s = state_q;
    end
    if ((state_q == ERASE) && first_frame_q) begin
      nxt_op_s.valid = 1'b0;
      nxt_op_s.op    = OP_BALL;
    end else begin
      nxt_op_s = next_op(op_q, skip_left_s, skip_right_s);
    end
  end

  pong_rect_mux #(
    .BALL_SIZE       (BALL_SIZE),
    .PADDLE_HEIGHT   (PADDLE_HEIGHT),
    .PADDLE_DEPTH    (PADDLE_DEPTH),
    .LEFT_PADDLE_X   (LEFT_PADDLE_X),
    .RIGHT_PADDLE_X  (RIGHT_PADDLE_X),
    .X_SCREEN_PIXELS (X_SCREEN_PIXELS),
    .Y_SCREEN_PIXELS (Y_SCREEN_PIXELS),
    .BG_COLOR        (BG_COLOR),
    .FG_COLOR        (FG_COLOR)
  ) u_rect_mux (
    .op_i          (sel_op_s),
    .phase_i       (sel_phase_s),
    .first_frame_i (first_frame_q),
    .old_ball_x_i  (old_ball_x_q),
    .old_ball_y_i  (old_ball_y_q),
    .old_left_y_i  (old_left_y_q),
    .old_right_y_i (old_right_y_q),
    .new_ball_x_i  (new_ball_x_q),
    .new_ball_y_i  (new_ball_y_q),
    .new_left_y_i  (new_left_y_q),
    .new_right_y_i (new_right_y_q),
    .rect_x_o      (rect_x_d),
    .rect_y_o      (rect_y_d),
    .rect_w_o      (rect_w_d),
    .rect_h_o      (rect_h_d),
    .rect_color_o  (rect_color_d)
  );

  // Sequencer FSM, fill handshake, position history and game-tick divider.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      op_q          <= OP_BALL;
      first_frame_q <= 1'b1;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      game_enable_q <= 1'b0;
      tick_cnt_q    <= 4'd0;
      old_ball_x_q  <= 10'd0;
      old_ball_y_q  <= 10'd0;
      old_left_y_q  <= 10'd0;
      old_right_y_q <= 10'd0;
      new_ball_x_q  <= 10'd0;
      new_ball_y_q  <= 10'd0;
      new_left_y_q  <= 10'd0;
      new_right_y_q <= 10'd0;
      rect_x_q      <= 10'd0;
      rect_y_q      <= 10'd0;
      rect_w_q      <= 10'd0;
      rect_h_q      <= 10'd0;
      rect_color_q  <= 3'b000;
    end else begin
      game_enable_q <= 1'b0;
      if (frame_start && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (frame_start) begin
            new_ball_x_q  <= ball_x;
            new_ball_y_q  <= ball_y;
            new_left_y_q  <= left_y;
            new_right_y_q <= right_y;
            state_q       <= ERASE;
            op_q          <= OP_BALL;
            busy_q        <= 1'b1;
            valid_q       <= 1'b1;
            rect_x_q      <= rect_x_d;
            rect_y_q      <= rect_y_d;
            rect_w_q      <= rect_w_d;
            rect_h_q      <= rect_h_d;
            rect_color_q  <= rect_color_d;
          end
        end
        ERASE, DRAW: begin
          if (valid_q) begin
            if (rect_ready) begin
              valid_q <= 1'b0;
              if (nxt_op_s.valid) begin
                op_q <= nxt_op_s.op;
              end else if (state_q == ERASE) begin
                state_q <= DRAW;
                op_q    <= OP_BALL;
              end else begin
                old_ball_x_q  <= new_ball_x_q;
                old_ball_y_q  <= new_ball_y_q;
                old_left_y_q  <= new_left_y_q;
                old_right_y_q <= new_right_y_q;
                first_frame_q <= 1'b0;
                state_q       <= TICK;
                if ((tick_cnt_q + 4'd1) == TICK_DIV_C) begin
                  game_enable_q <= 1'b1;
                  tick_cnt_q    <= 4'd0;
                end else begin
                  tick_cnt_q <= tick_cnt_q + 4'd1;
                end
              end
            end
          end else begin
            // Gap cycle after a transfer: present the newly entered op.
            valid_q      <= 1'b1;
            rect_x_q     <= rect_x_d;
            rect_y_q     <= rect_y_d;
            rect_w_q     <= rect_w_d;
            rect_h_q     <= rect_h_d;
            rect_color_q <= rect_color_d;
          end
        end
        TICK: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign rect_valid  = valid_q;
  assign rect_x      = rect_x_q;
  assign rect_y      = rect_y_q;
  assign rect_w      = rect_w_q;
  assign rect_h      = rect_h_q;
  assign rect_color  = rect_color_q;
  assign game_enable = game_enable_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;

endmodule
